ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Writer-side counterpart to the team's BRAM-backed ROM.
- Accepts a byte stream over a valid/ready handshake and packs the bytes into n-bit words.
- Writes the words sequentially into an internal m x n block RAM, starting at address 0.
- Exposes a registered random-access read port, so a loaded table (bootloader image, LUT, sprite data) is readable by the rest of the design.

Parameters:
- n, 16, word width; must be a multiple of 8 (8, 16, 32 supported); k = n/8 bytes per word.
- m, 512, memory depth in words; need not be a power of two.

Ports:
- clk, input, 1, single clock; all state changes on posedge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse that begins or restarts a load.
- in_data, input, 8, byte stream data.
- in_valid, input, 1, in_data holds a valid byte.
- in_ready, output, 1, loader accepts a byte this cycle.
- busy, output, 1, high while in LOAD.
- done, output, 1, high once all m words have been written; held until the next start or rst.
- words, output, clog2(m+1), number of complete words written in the current load.
- address, input, clog2(m), read address.
- data_o, output, n, registered read data.

Behaviour:
- States: IDLE, LOAD, DONE.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; write pointer = 0; byte index = 0; words = 0.
  - in_ready = 0, busy = 0, done = 0, data_o = 0.
  - Memory contents are not cleared.
- in_ready = busy = (state == LOAD), decoded combinationally from the state register.
- start in IDLE or DONE:
  - Next edge: state = LOAD, pointer = 0, byte index = 0, words = 0, done = 0.
- start during LOAD:
  - Restarts the load with the same resets as above.
  - Any partial word is discarded.
  - A byte presented in the same cycle is dropped; start wins.
- Byte acceptance: a byte is accepted on a posedge with in_valid & in_ready.
  - Byte j (0..k-1) of a word goes to bits [8j+7:8j], i.e. little-endian, first byte is least significant.
- On the edge accepting byte k-1:
  - The full word is written to mem[pointer] on that same edge.
  - pointer and words increment; byte index returns to 0.
- On the edge writing word m-1:
  - state = DONE, done = 1, in_ready falls the next cycle.
  - No bytes are accepted in DONE or IDLE.
- in_valid without in_ready: ignored, no side effects.
- Read port: data_o <= mem[address] on every posedge, giving 1-cycle latency.
- Read-during-write to the same address returns the old contents. The new word is readable from the edge after the write edge.
- Out-of-range address (address >= m when m is not a power of two): data_o is undefined but must not disturb the write side.
- Mid-load reset: the load aborts; words already written stay in memory.
- Implementation must infer iCE40 block RAM: one synchronous write port, one synchronous read port, no reset on the memory array.

Decomposition:
- No shared package; the codebase is plain Verilog.
- k and the state encodings are localparams in the module.
- Natural sub-module: byte_packer(n). It holds the byte index and shift register and emits a one-cycle word_valid together with the assembled word.
- ram_loader keeps the FSM, write pointer, memory array and read register.

Test Plan:
- Reset then idle (n=16, m=4): in_valid=1 with in_data=0xAA for 10 cycles, no start -> in_ready=0, words=0, done=0, data_o=0.
- Full load (n=16, m=4): start, then stream bytes 01 02 03 04 05 06 07 08 with in_valid continuous -> words steps 1..4 after every second byte; done=1 the cycle after the 8th byte edge; reading addresses 0..3 returns 0x0201, 0x0403, 0x0605, 0x0807, each one cycle after the address is applied.
- Backpressure/gaps: same load with in_valid toggling 1,0,1,0 -> identical memory contents; no bytes are lost or duplicated.
- Restart mid-word: start, send 0x11, then start+in_valid with 0x22, then bytes 33 44 -> mem[0] = 0x4433; 0x11 and 0x22 are discarded.
- Read-during-write: address held at 1 while word 1 (0xBEEF) is written over an old value of 0x1234 -> data_o is 0x1234 for the write-edge read, then 0xBEEF.
- Async reset mid-load: assert rst between edges after 3 bytes -> in_ready, busy and done drop immediately; mem[0] keeps its value; a new start reloads from address 0.

Source files
------------

// File: rtl/ram_loader_byte_packer.sv
// byte_packer: collects bytes into n-bit words, little-endian (first byte
// lands in bits [7:0]). word_valid is combinational and pulses on the cycle
// whose accepted byte completes a word, so the caller can write the word on
// that same edge.
//
// Ports:
//   clk        - clock
//   rst        - asynchronous active-high reset
//   clear      - drop any partial word, byte index back to 0
//   byte_en    - a byte is accepted on this edge (already qualified by caller)
//   in_data    - byte being accepted
//   word_valid - this edge completes a word
//   word       - assembled word, valid while word_valid is high
module byte_packer #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         byte_en,
    input  logic [7:0]   in_data,
    output logic         word_valid,
    output logic [n-1:0] word
);

    localparam int k = n / 8;

    generate
        if (k == 1) begin : g_single
            assign word_valid = byte_en;
            assign word       = in_data;
        end else begin : g_multi
            localparam int IW = $clog2(k);
            localparam logic [IW-1:0] LAST_IDX = IW'(k - 1);

            logic [IW-1:0] idx_q;
            // Holds the k-1 earlier bytes of the word; the final byte comes
            // straight from in_data so the word is complete on its own edge.
            logic [n-9:0]  sr_q;
            logic [n-9:0]  sr_next;

            if (k == 2) begin : g_sr2
                assign sr_next = in_data;
            end else begin : g_srk
                assign sr_next = {in_data, sr_q[n-9:8]};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    idx_q <= '0;
                    sr_q  <= '0;
                end else if (clear) begin
                    idx_q <= '0;
                end else if (byte_en) begin
                    idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    sr_q  <= sr_next;
                end
            end

            assign word_valid = byte_en && (idx_q == LAST_IDX);
            assign word       = {in_data, sr_q};
        end
    endgenerate

endmodule

// File: rtl/ram_loader.sv
// ram_loader: loads a byte stream into an m x n block RAM, word by word from
// address 0, and exposes a registered random-access read port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset; no bytes accepted, waiting for start
// LOAD  | accepting bytes; in_ready = busy = 1
// DONE  | all m words written; done held until next start or rst
//
// Ports:
//   clk      - clock, all state changes on posedge
//   rst      - asynchronous active-high reset (memory array is not cleared)
//   start    - one-cycle pulse, begins or restarts a load
//   in_data  - byte stream data
//   in_valid - in_data holds a valid byte
//   in_ready - loader accepts a byte this cycle
//   busy     - high while loading
//   done     - high once all m words have been written
//   words    - complete words written in the current load
//   address  - read address
//   data_o   - registered read data, one cycle after address
module ram_loader #(
    parameter int n = 16,
    parameter int m = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(m+1)-1:0]   words,
    input  logic [$clog2(m)-1:0]     address,
    output logic [n-1:0]             data_o
);

    localparam int AW = $clog2(m);
    localparam int WW = $clog2(m + 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(m - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [WW-1:0]   words_q;
    logic            accept;
    logic            word_valid;
    logic [n-1:0]    packed_word;
    logic [AW-1:0]   wr_addr;
    logic [n-1:0]    mem [0:m-1];

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q == LOAD);
    assign done     = (state_q == DONE);
    assign words    = words_q;

    // A start in the same cycle as a byte wins: the byte is dropped.
    assign accept = in_valid && in_ready && !start;

    byte_packer #(.n(n)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .byte_en    (accept),
        .in_data    (in_data),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (start) begin
                    state_d = LOAD;
                end else if (word_valid && (words_q == LAST_WORD)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // words doubles as the write pointer: it is the address of the next word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
        end else if (start) begin
            words_q <= '0;
        end else if (word_valid) begin
            words_q <= words_q + 1'b1;
        end
    end

    assign wr_addr = words_q[AW-1:0];

    // Memory array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (word_valid) begin
            mem[wr_addr] <= packed_word;
        end
    end

    // Read-during-write to the same address returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o <= '0;
        end else begin
            data_o <= mem[address];
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

    localparam int N  = 16;
    localparam int M  = 4;
    localparam int AW = $clog2(M);
    localparam int WW = $clog2(M + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [WW-1:0] words;
    logic [AW-1:0] address = '0;
    logic [N-1:0]  data_o;

    int checks = 0;
    int errors = 0;

    // Reference model of the loader
    logic [N-1:0] model_mem [M];
    logic [7:0]   pend_b;
    int           pend_n;
    int           mptr;
    bit           mload;
    bit           mdone;

    // Scoreboard: expected read data pushed when the address is applied
    logic [N-1:0] exp_q [$];
    logic [N-1:0] exp_v;

    ram_loader #(.n(N), .m(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .words    (words),
        .address  (address),
        .data_o   (data_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start();
        mload  = 1'b1;
        mdone  = 1'b0;
        mptr   = 0;
        pend_n = 0;
    endtask

    task automatic model_reset();
        mload  = 1'b0;
        mdone  = 1'b0;
        mptr   = 0;
        pend_n = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (mload) begin
            if (pend_n == 0) begin
                pend_b = b;
                pend_n = 1;
            end else begin
                model_mem[mptr] = {b, pend_b};
                mptr   = mptr + 1;
                pend_n = 0;
                if (mptr == M) begin
                    mload = 1'b0;
                    mdone = 1'b1;
                end
            end
        end
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        model_start();
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        model_reset();
        checks++;
        if (data_o !== '0) begin
            errors++;
            $display("FAIL reset_data_o: got %h expected %h", data_o, 16'h0000);
        end
        checks++;
        if ({in_ready, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {in_ready, busy, done});
        end
        rst = 1'b0;
        in_data  = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            model_byte(8'hAA);
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== mload || busy !== mload) begin
            errors++;
            $display("FAIL idle_ready: got in_ready=%b busy=%b expected %b", in_ready, busy, mload);
        end
        checks++;
        if (words !== WW'(mptr)) begin
            errors++;
            $display("FAIL idle_words: got %0d expected %0d", words, mptr);
        end
        checks++;
        if (done !== mdone) begin
            errors++;
            $display("FAIL idle_done: got %b expected %b", done, mdone);
        end
    endtask

    task automatic test_full_load();
        pulse_start();
        for (int b = 1; b <= 8; b++) begin
            in_data  = 8'(b);
            in_valid = 1'b1;
            step();
            model_byte(8'(b));
            checks++;
            if (words !== WW'(mptr)) begin
                errors++;
                $display("FAIL load_words byte %0d: got %0d expected %0d", b, words, mptr);
            end
        end
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b0 || done !== mdone) begin
            errors++;
            $display("FAIL load_done: got done=%b in_ready=%b expected done=1 in_ready=0", done, in_ready);
        end
        // Bytes offered in DONE must be ignored
        in_data = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            step();
            model_byte(8'hEE);
        end
        in_valid = 1'b0;
        checks++;
        if (words !== WW'(M) || done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: got words=%0d done=%b expected %0d 1", words, done, M);
        end
        for (int a = 0; a < M; a++) begin
            address = AW'(a);
            exp_q.push_back(model_mem[a]);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (data_o !== exp_v) begin
                errors++;
                $display("FAIL load_read addr %0d: got %h expected %h", a, data_o, exp_v);
            end
        end
    endtask

    task automatic test_gaps();
        logic [7:0] b;
        pulse_start();
        checks++;
        if (done !== 1'b0 || words !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL gaps_start: got done=%b words=%0d in_ready=%b expected 0 0 1", done, words, in_ready);
        end
        for (int i = 0; i < 16; i++) begin
            b = 8'hC1 + 8'(i / 2);
            in_valid = (i % 2 == 0);
            in_data  = (i % 2 == 0) ? b : 8'hFF;
            step();
            if (i % 2 == 0) model_byte(b);
            checks++;
            if (words !== WW'(mptr)) begin
                errors++;
                $display("FAIL gaps_words cycle %0d: got %0d expected %0d", i, words, mptr);
            end
        end
        in_valid = 1'b0;
        for (int a = 0; a < M; a++) begin
            address = AW'(a);
            exp_q.push_back(model_mem[a]);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (data_o !== exp_v) begin
                errors++;
                $display("FAIL gaps_read addr %0d: got %h expected %h", a, data_o, exp_v);
            end
        end
    endtask

    task automatic test_restart_mid_word();
        pulse_start();
        send(8'h11);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h22;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        model_start();
        checks++;
        if (words !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_state: got words=%0d in_ready=%b expected 0 1", words, in_ready);
        end
        send(8'h33);
        send(8'h44);
        checks++;
        if (words !== WW'(mptr)) begin
            errors++;
            $display("FAIL restart_words: got %0d expected %0d", words, mptr);
        end
        address = '0;
        exp_q.push_back(model_mem[0]);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (data_o !== exp_v || exp_v !== 16'h4433) begin
            errors++;
            $display("FAIL restart_read: got %h expected %h", data_o, 16'h4433);
        end
    endtask

    task automatic test_read_during_write();
        pulse_start();
        send(8'h00); send(8'h00); send(8'h34); send(8'h12);
        pulse_start();
        send(8'h00); send(8'h00);
        address  = AW'(1);
        in_valid = 1'b1;
        in_data  = 8'hEF;
        exp_q.push_back(model_mem[1]);
        step();
        model_byte(8'hEF);
        in_data = 8'hBE;
        exp_v = exp_q.pop_front();
        checks++;
        if (data_o !== exp_v) begin
            errors++;
            $display("FAIL rdw_before: got %h expected %h", data_o, exp_v);
        end
        exp_q.push_back(model_mem[1]);
        step();
        model_byte(8'hBE);
        in_valid = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (data_o !== exp_v || exp_v !== 16'h1234) begin
            errors++;
            $display("FAIL rdw_write_edge: got %h expected %h", data_o, 16'h1234);
        end
        exp_q.push_back(model_mem[1]);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (data_o !== exp_v || exp_v !== 16'hBEEF) begin
            errors++;
            $display("FAIL rdw_after: got %h expected %h", data_o, 16'hBEEF);
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        send(8'h5A); send(8'hA5); send(8'h77);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({in_ready, busy, done} !== 3'b000 || words !== '0) begin
            errors++;
            $display("FAIL async_rst_load: got flags=%b words=%0d expected 000 0", {in_ready, busy, done}, words);
        end
        rst = 1'b0;
        address = '0;
        exp_q.push_back(model_mem[0]);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (data_o !== exp_v || exp_v !== 16'hA55A) begin
            errors++;
            $display("FAIL async_rst_keep: got %h expected %h", data_o, 16'hA55A);
        end
        pulse_start();
        send(8'h01); send(8'h02);
        checks++;
        if (words !== WW'(1)) begin
            errors++;
            $display("FAIL reload_words: got %0d expected 1", words);
        end
        exp_q.push_back(model_mem[0]);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (data_o !== exp_v || exp_v !== 16'h0201) begin
            errors++;
            $display("FAIL reload_read: got %h expected %h", data_o, 16'h0201);
        end
        for (int b = 3; b <= 8; b++) send(8'(b));
        checks++;
        if (done !== mdone || done !== 1'b1) begin
            errors++;
            $display("FAIL reload_done: got %b expected 1", done);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (done !== mdone) begin
            errors++;
            $display("FAIL async_rst_done: got %b expected %b", done, mdone);
        end
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0;
        #1;
        for (int i = 0; i < M; i++) model_mem[i] = '0;
        model_reset();
        test_reset();
        test_full_load();
        test_gaps();
        test_restart_mid_word();
        test_read_during_write();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
